// File: rtl/tt_um_carlos_gs99.sv
// Unsigned sequential shift-add multiplier. Watches its operand inputs and
// recomputes automatically whenever either operand changes; the product
// register only updates once a full computation over stable operands finishes.
module tt_um_carlos_gs99 #(
    parameter int bits = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [bits-1:0]     A,
    input  logic [bits-1:0]     B,
    output logic [2*bits-1:0]   Product_o
);

    localparam int CW = $clog2(bits + 1);

    localparam logic [0:0] HOLD = 1'b0;
    localparam logic [0:0] CALC = 1'b1;

    logic [bits-1:0]   a_cap;
    logic [bits-1:0]   b_cap;
    logic [2*bits-1:0] acc;
    logic [2*bits-1:0] mcand;
    logic [bits-1:0]   mplier;
    logic [CW-1:0]     cnt;
    logic [0:0]        state;

    logic              changed;
    logic [2*bits-1:0] addend;
    logic [2*bits-1:0] sum;
    logic              last_iter;

    // Operand change detection and the per-cycle partial-product sum.
    // The sum is 2*bits wide, which always holds the full product.
    always_comb begin
        changed   = ({A, B} != {a_cap, b_cap});
        addend    = mplier[0] ? mcand : '0;
        sum       = acc + addend;
        last_iter = (cnt == CW'(bits - 1));
    end

    // Capture/restart on any operand change; otherwise step the shift-add
    // loop and publish the final sum on the last iteration only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Product_o <= '0;
            a_cap     <= '0;
            b_cap     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            state     <= HOLD;
        end else if (changed) begin
            a_cap     <= A;
            b_cap     <= B;
            acc       <= '0;
            mcand     <= {{bits{1'b0}}, A};
            mplier    <= B;
            cnt       <= '0;
            state     <= CALC;
        end else if (state == CALC) begin
            acc       <= sum;
            mcand     <= mcand << 1;
            mplier    <= mplier >> 1;
            cnt       <= cnt + CW'(1);
            if (last_iter) begin
                Product_o <= sum;
                state     <= HOLD;
            end
        end
    end

endmodule

// File: tb/tb_tt_um_carlos_gs99.sv
// Directed bench for the shift-add multiplier: reset behaviour, exact latency,
// exhaustive 4-bit sweep, abort/restart, async reset mid-computation, and a
// second instance with 8-bit operands.
module tb_tt_um_carlos_gs99;

    logic        clk;
    logic        rst;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  p4;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic [15:0] p8;

    int total;
    int bad;

    tt_um_carlos_gs99 #(.bits(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .A         (a4),
        .B         (b4),
        .Product_o (p4)
    );

    tt_um_carlos_gs99 #(.bits(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .A         (a8),
        .B         (b8),
        .Product_o (p8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        a4    = 4'd0;
        b4    = 4'd0;
        a8    = 8'd0;
        b8    = 8'd0;

        // Reset with zero operands: product stays 0 during and after reset.
        tick(2);
        check("reset_p4", {8'd0, p4}, 16'd0);
        check("reset_p8", p8, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("zero_hold", {8'd0, p4}, 16'd0);
        end

        // 3*5: old value for 4 edges, 15 on the 5th, then held.
        a4 = 4'd3;
        b4 = 4'd5;
        for (int e = 1; e <= 4; e++) begin
            tick(1);
            check("lat_3x5_old", {8'd0, p4}, 16'd0);
        end
        tick(1);
        check("lat_3x5_new", {8'd0, p4}, 16'd15);
        tick(3);
        check("lat_3x5_hold", {8'd0, p4}, 16'd15);

        // Exhaustive 4-bit sweep, each pair held 10 cycles.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                a4 = 4'(ia);
                b4 = 4'(ib);
                tick(10);
                check($sformatf("sweep_%0dx%0d", ia, ib), {8'd0, p4}, 16'(ia * ib));
            end
        end

        // Abort/restart: 7*9 interrupted by 12*11; 63 must never appear.
        a4 = 4'd7;
        b4 = 4'd9;
        tick(2);
        check("abort_old_a", {8'd0, p4}, 16'd225);
        a4 = 4'd12;
        b4 = 4'd11;
        for (int e = 1; e <= 4; e++) begin
            tick(1);
            check("abort_old_b", {8'd0, p4}, 16'd225);
        end
        tick(1);
        check("abort_new", {8'd0, p4}, 16'd132);
        tick(6);
        check("abort_hold", {8'd0, p4}, 16'd132);

        // Async reset mid-computation of 15*15.
        a4 = 4'd15;
        b4 = 4'd15;
        tick(2);
        check("midrst_before", {8'd0, p4}, 16'd132);
        rst = 1'b1;
        #1;
        check("midrst_async", {8'd0, p4}, 16'd0);
        tick(1);
        check("midrst_held", {8'd0, p4}, 16'd0);
        rst = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            tick(1);
            check("midrst_wait", {8'd0, p4}, 16'd0);
        end
        tick(1);
        check("midrst_result", {8'd0, p4}, 16'd225);

        // 8-bit instance: 9-edge latency.
        a8 = 8'd255;
        b8 = 8'd255;
        for (int e = 1; e <= 8; e++) begin
            tick(1);
            check("w8_wait", p8, 16'd0);
        end
        tick(1);
        check("w8_255x255", p8, 16'd65025);
        a8 = 8'd128;
        b8 = 8'd2;
        tick(8);
        check("w8_128x2_old", p8, 16'd65025);
        tick(1);
        check("w8_128x2", p8, 16'd256);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tt_um_carlos_gs99.md
# tt_um_carlos_gs99

Unsigned sequential shift-add multiplier for the Tiny Tapeout user slot. It multiplies two `bits`-wide operands and drives a registered `2*bits`-wide product. The block has no start/done handshake: it monitors its operand inputs and recomputes automatically whenever either operand changes. It is a top-level user module driven directly from chip pins.

## Interface
- `bits`, default 4: operand width; product width is `2*bits`; legal range 2..16.

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  reset; one clock; reset is asynchronous and active-high.
- `A`  input  `bits`  multiplicand, unsigned.
- `B`  input  `bits`  multiplier, unsigned.
- `Product_o`  output  `2*bits`  registered product `A*B`, unsigned.

## Operation
Internal registers:
- `a_cap`, `b_cap`: captured operands (`bits` each).
- `acc`: accumulator (`2*bits`).
- `mcand`: shifted multiplicand (`2*bits`).
- `mplier`: shifted multiplier (`bits`).
- `cnt`: iteration counter, `ceil(log2(bits+1))` bits.
- `state`: one of HOLD or CALC.

Change detection runs in every state, every cycle. If `{A,B} != {a_cap,b_cap}`, the LOAD action occurs on that edge:
- `a_cap<=A`, `b_cap<=B`.
- `acc<=0`, `mcand<=zero-extended A`, `mplier<=B`, `cnt<=0`.
- `state<=CALC`.

A change during CALC aborts the current computation and restarts it with the new operands. `Product_o` keeps its old value until the new result completes.

HOLD (no operand change): idle; `Product_o` is held.

CALC (no operand change), each cycle:
- If `mplier[0]`, then `acc<=acc+mcand`.
- `mcand<=mcand<<1`, `mplier<=mplier>>1`, `cnt<=cnt+1`.
- On the cycle where `cnt==bits-1`:
  - `Product_o<=acc+(mplier[0]?mcand:0)`, the final sum.
  - `state<=HOLD`.

Arithmetic rules:
- The add is `2*bits` wide; overflow is impossible since max product `(2^bits-1)^2 < 2^(2*bits)`.
- No signed mode.

## Timing
- Reset (async, active-high) sets:
  - `Product_o=0`
  - `a_cap=0`, `b_cap=0`
  - `acc=0`, `mcand=0`, `mplier=0`, `cnt=0`
  - `state=HOLD`
- Reset mid-computation discards the computation.
- After release: if `A=B=0`, `Product_o` stays 0 with no computation. Otherwise a computation starts on the first edge after release.
- Latency: the new product appears on `Product_o` exactly `bits+1` rising edges after the operands change and remain stable.
  - 1 edge for LOAD, `bits` edges for CALC.
  - `bits=4`: 5 cycles, i.e. 50 ns at 100 MHz.
- Throughput: one product per `bits+1` cycles when operands change at least that far apart.
- Operands changing more often than every `bits+1` cycles: `Product_o` never updates until they are stable for `bits+1` cycles. No intermediate or partial value is ever driven.
- `Product_o` changes only on a clock edge or on reset assertion. It is glitch-free and a direct register output.
- Unknown (X) inputs: `Product_o` is undefined until known inputs have been stable for `bits+1` cycles.

## Test plan
- Reset, then A=0, B=0 -> `Product_o=0` during reset and for 20 cycles after. `state` stays HOLD.
- A=3, B=5 held -> `Product_o` changes from its previous value to 15 exactly on the 5th edge after the change, then holds.
- Exhaustive `bits=4` sweep: all 256 (A,B) pairs, each held 10 cycles, sampled at the end -> `Product_o==A*B`. Max is 15*15=225 (8'hE1). Corners: 0*15=0, 15*0=0, 1*15=15.
- Abort/restart: A=7, B=9; after 2 cycles change to A=12, B=11 -> `Product_o` never shows 63. It shows 132 exactly 5 edges after the second change.
- Reset mid-computation: A=15, B=15; assert `rst` 2 cycles later -> `Product_o=0` immediately (asynchronous). After release with A=15, B=15 still applied -> 225 exactly 5 edges later.
- Parameter check `bits=8`: A=255, B=255 -> `Product_o=65025` after 9 edges. A=128, B=2 -> 256.
